// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared constants for the VGA raster timing generator and its axis counters.
// Holds the default 640x480@60 mode (800x525 total), the derived totals and
// sync-window boundaries, the default sync polarity, the bundle type used for
// the registered control outputs, and small helpers for the axis arithmetic.
//
// No ports (package).
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  // Default horizontal timing, in pixels
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  // Default vertical timing, in lines
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Counter width; both totals must fit in 2^DEF_CNT_W
  localparam int unsigned DEF_CNT_W    = 10;

  // Asserted level of hsync/vsync (0 = active-low, as standard VGA modes use)
  localparam logic        DEF_SYNC_POL = 1'b0;

  // Derived totals for the default mode (800 x 525)
  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows for the default mode: start inclusive, end exclusive
  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Registered single-bit outputs of the generator, grouped so that their
  // reset value and next value are built in one place each.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic lineStart;
    logic frameStart;
  } vga_ctrl_t;

  // Total length of one axis from its four segments
  function automatic int unsigned axisTotal(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Pin level for a sync signal given whether it is asserted and the polarity
  function automatic logic syncLevel(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// ----------------------------------------------------------------------------
// vga_axis_cnt
//
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each step and
// wraps back to 0 by terminal compare. Also decodes, combinationally from the
// current count, whether the position lies in the visible region and whether
// it lies in the sync window.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset, clears the count
//   step       in   advance the count by one (pixel strobe or line wrap)
//   count      out  current count, 0..TOTAL-1
//   wrap       out  step taken while at TOTAL-1 (count returns to 0 next clk)
//   in_active  out  count < ACTIVE
//   in_sync    out  ACTIVE+FP <= count < ACTIVE+FP+SYNC
// ----------------------------------------------------------------------------
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_active,
  output logic             in_sync
);

  localparam int unsigned TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);

  // Boundaries are held one bit wider than the counter so that a sync window
  // ending exactly at 2^CNT_W (zero back porch, full-width total) still
  // compares correctly instead of wrapping to zero.
  localparam logic [CNT_W:0] LAST_CNT   = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] ACTIVE_END = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] SYNC_START = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_END   = (CNT_W+1)'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_countExt;
  logic             w_terminal;

  assign w_countExt = {1'b0, r_count};
  assign w_terminal = (w_countExt == LAST_CNT);

  // The counter wraps by comparing against the terminal value, never by
  // running off the top of its width, so non-power-of-two totals work.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (step) begin
      if (w_terminal) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign count     = r_count;
  assign wrap      = w_terminal & step;
  assign in_active = (w_countExt < ACTIVE_END);
  assign in_sync   = (w_countExt >= SYNC_START) && (w_countExt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster timing generator. Consumes the one-clk pixel strobe from the
// divide-by-4 block and produces sync, active-video, pixel coordinates and
// line/frame start pulses for the renderer and the DAC pins.
//
// Two axis counters do the counting: the horizontal one steps on pix_en, the
// vertical one steps on the horizontal wrap. Every output is a registered
// decode of the counters, so outputs trail the counters by one clk and change
// only in the clk after a strobe.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   pix_en       in   one-clk pixel strobe (may be held at 1)
//   hsync        out  horizontal sync, asserted level SYNC_POL
//   vsync        out  vertical sync, asserted level SYNC_POL
//   active       out  position is inside the visible area
//   hpos         out  horizontal position 0..H_TOTAL-1
//   vpos         out  vertical position 0..V_TOTAL-1
//   line_start   out  one-clk pulse when hpos re-enters 0 by wrapping
//   frame_start  out  one-clk pulse when (hpos,vpos) re-enters (0,0) by wrapping
// ----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start
);

  // Value of the control bundle while in reset: syncs deasserted, no video,
  // no pulses.
  localparam vga_ctrl_t CTRL_RESET = '{
    hsync:      ~SYNC_POL,
    vsync:      ~SYNC_POL,
    active:     1'b0,
    lineStart:  1'b0,
    frameStart: 1'b0
  };

  logic [CNT_W-1:0] w_hCount;
  logic [CNT_W-1:0] w_vCount;
  logic             w_hWrap;
  logic             w_vWrap;
  logic             w_hInActive;
  logic             w_vInActive;
  logic             w_hInSync;
  logic             w_vInSync;

  vga_ctrl_t        w_ctrlNext;
  vga_ctrl_t        r_ctrl;
  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic             r_hWrapD;
  logic             r_frameWrapD;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_hAxis (
    .clk       (clk),
    .reset     (reset),
    .step      (pix_en),
    .count     (w_hCount),
    .wrap      (w_hWrap),
    .in_active (w_hInActive),
    .in_sync   (w_hInSync)
  );

  // The vertical axis only moves when a line ends, so vsync and vpos can only
  // change alongside the horizontal wrap.
  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_vAxis (
    .clk       (clk),
    .reset     (reset),
    .step      (w_hWrap),
    .count     (w_vCount),
    .wrap      (w_vWrap),
    .in_active (w_vInActive),
    .in_sync   (w_vInSync)
  );

  // Next value of the control outputs. Sync and active are decodes of the
  // current counters. The pulses come from the wrap seen one clk earlier:
  // the wrap happens on the strobe edge, the counters show 0 after that edge,
  // and the registered outputs show 0 one clk later, so the pulse has to be
  // delayed by the same one clk to line up with hpos=0.
  always_comb begin
    w_ctrlNext            = CTRL_RESET;
    w_ctrlNext.hsync      = syncLevel(w_hInSync, SYNC_POL);
    w_ctrlNext.vsync      = syncLevel(w_vInSync, SYNC_POL);
    w_ctrlNext.active     = w_hInActive & w_vInActive;
    w_ctrlNext.lineStart  = r_hWrapD;
    w_ctrlNext.frameStart = r_frameWrapD;
  end

  // Output registers. Because the counters only move on a strobe, reloading
  // the decode every clk still leaves the outputs stable between strobes,
  // while the wrap delay stages clear themselves after one clk so each pulse
  // is exactly one clk wide. Clearing the delay stages in reset keeps a wrap
  // that coincides with reset from leaking out as a pulse afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl       <= CTRL_RESET;
      r_hpos       <= '0;
      r_vpos       <= '0;
      r_hWrapD     <= 1'b0;
      r_frameWrapD <= 1'b0;
    end else begin
      r_ctrl       <= w_ctrlNext;
      r_hpos       <= w_hCount;
      r_vpos       <= w_vCount;
      r_hWrapD     <= w_hWrap;
      r_frameWrapD <= w_vWrap;
    end
  end

  assign hsync       = r_ctrl.hsync;
  assign vsync       = r_ctrl.vsync;
  assign active      = r_ctrl.active;
  assign line_start  = r_ctrl.lineStart;
  assign frame_start = r_ctrl.frameStart;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. The horizontal axis runs the default
// 800-pixel line; the vertical axis is shortened to 20 lines (12 visible,
// porch 2, sync 2, back porch 4) so a full frame is 16000 clks and the whole
// run stays short. Vsync therefore spans lines 14..15 here.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_ACTIVE   = 12;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 4;
  localparam int CNT_W      = 10;
  localparam int H_TOTAL    = 800;
  localparam int FRAME_CLKS = 16000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pix_en = 1'b0;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             line_start;
  logic             frame_start;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (1'b0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  // Advance one clock and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with pix_en=1 for n clks; the next tick is clk 1 after release
  task automatic doReset(input int n);
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      assertCount++;
      if ({hsync, vsync, active, line_start, frame_start} !== 5'b11000 ||
          hpos !== '0 || vpos !== '0) begin
        failCount++;
        $display("[TB] FAIL reset_hold clk %0d: hs=%b vs=%b act=%b hpos=%0d vpos=%0d ls=%b fs=%b, expected 1 1 0 0 0 0 0",
                 i, hsync, vsync, active, hpos, vpos, line_start, frame_start);
      end
    end
  endtask

  task automatic test_line();
    int activeClks = 0;
    int lastActive = -1;
    int hsLow = 0;
    int hsFirstHpos = -1;
    int lsCount = 0;
    int lsAt = -1;
    int lsVpos = -1;
    int lsHpos = -1;
    int fsCount = 0;
    int posErr = 0;
    doReset(2);
    for (int n = 1; n <= H_TOTAL + 1; n++) begin
      tick();
      if (n == 1) begin
        assertCount++;
        if ({hsync, vsync, active, line_start, frame_start} !== 5'b11100 ||
            hpos !== '0 || vpos !== '0) begin
          failCount++;
          $display("[TB] FAIL first_clk: hs=%b vs=%b act=%b hpos=%0d vpos=%0d ls=%b fs=%b, expected 1 1 1 0 0 0 0",
                   hsync, vsync, active, hpos, vpos, line_start, frame_start);
        end
      end
      if (n <= H_TOTAL && active) begin
        activeClks++;
        lastActive = n;
      end
      if (!hsync) begin
        hsLow++;
        if (hsFirstHpos < 0) hsFirstHpos = int'(hpos);
      end
      if (line_start) begin
        lsCount++;
        lsAt   = n;
        lsVpos = int'(vpos);
        lsHpos = int'(hpos);
      end
      if (frame_start) fsCount++;
      if (hpos !== CNT_W'((n - 1) % H_TOTAL) || vpos !== CNT_W'((n - 1) / H_TOTAL)) posErr++;
    end
    assertCount++;
    if (activeClks !== 640) begin
      failCount++;
      $display("[TB] FAIL active_clks: got %0d, expected 640", activeClks);
    end
    assertCount++;
    if (lastActive !== 640) begin
      failCount++;
      $display("[TB] FAIL active_last_clk: got %0d, expected 640", lastActive);
    end
    assertCount++;
    if (hsLow !== 96) begin
      failCount++;
      $display("[TB] FAIL hsync_low_clks: got %0d, expected 96", hsLow);
    end
    assertCount++;
    if (hsFirstHpos !== 656) begin
      failCount++;
      $display("[TB] FAIL hsync_entry_hpos: got %0d, expected 656", hsFirstHpos);
    end
    assertCount++;
    if (lsCount !== 1 || lsAt !== 801 || lsVpos !== 1 || lsHpos !== 0) begin
      failCount++;
      $display("[TB] FAIL line_start_first: count=%0d at=%0d vpos=%0d hpos=%0d, expected 1 801 1 0",
               lsCount, lsAt, lsVpos, lsHpos);
    end
    assertCount++;
    if (fsCount !== 0) begin
      failCount++;
      $display("[TB] FAIL frame_start_in_line: got %0d pulses, expected 0", fsCount);
    end
    assertCount++;
    if (posErr !== 0) begin
      failCount++;
      $display("[TB] FAIL position_track: got %0d bad clks, expected 0", posErr);
    end
  endtask

  task automatic test_frame();
    int vsLow = 0;
    int vsFirstVpos = -1;
    int vsEdgeErr = 0;
    int fsCount = 0;
    int fsAt = -1;
    int fsBad = 0;
    int lsCount = 0;
    int releasePulse = 0;
    logic prevVs = 1'b1;
    doReset(2);
    for (int n = 1; n <= FRAME_CLKS + 1; n++) begin
      tick();
      if (n == 1 && (line_start || frame_start)) releasePulse++;
      if (!vsync) begin
        vsLow++;
        if (vsFirstVpos < 0) vsFirstVpos = int'(vpos);
      end
      if (n > 1 && vsync !== prevVs && hpos !== '0) vsEdgeErr++;
      prevVs = vsync;
      if (line_start) lsCount++;
      if (frame_start) begin
        fsCount++;
        fsAt = n;
        if (!line_start || hpos !== '0 || vpos !== '0) fsBad++;
      end
    end
    assertCount++;
    if (releasePulse !== 0) begin
      failCount++;
      $display("[TB] FAIL pulse_at_release: got %0d, expected 0", releasePulse);
    end
    assertCount++;
    if (vsLow !== 1600 || vsFirstVpos !== 14) begin
      failCount++;
      $display("[TB] FAIL vsync_low: clks=%0d entry_vpos=%0d, expected 1600 14", vsLow, vsFirstVpos);
    end
    assertCount++;
    if (vsEdgeErr !== 0) begin
      failCount++;
      $display("[TB] FAIL vsync_edge_align: got %0d edges off hpos 0, expected 0", vsEdgeErr);
    end
    assertCount++;
    if (fsCount !== 1 || fsAt !== FRAME_CLKS + 1 || fsBad !== 0) begin
      failCount++;
      $display("[TB] FAIL frame_start: count=%0d at=%0d bad=%0d, expected 1 %0d 0",
               fsCount, fsAt, fsBad, FRAME_CLKS + 1);
    end
    assertCount++;
    if (lsCount !== 20) begin
      failCount++;
      $display("[TB] FAIL line_start_count: got %0d, expected 20", lsCount);
    end
  endtask

  task automatic test_div4();
    logic [2*CNT_W+2:0] prevBundle = '0;
    logic [2*CNT_W+2:0] bundle;
    logic pePrev = 1'b0;
    logic lsPrev = 1'b0;
    logic fsPrev = 1'b0;
    int chgErr = 0;
    int widthErr = 0;
    int lsCount = 0;
    int lsFirst = -1;
    int lsSecond = -1;
    int lsFirstVpos = -1;
    int run = 0;
    int firstRun = -1;
    doReset(2);
    for (int k = 0; k < 7000; k++) begin
      pix_en = (k % 4 == 0);
      tick();
      bundle = {hsync, vsync, active, hpos, vpos};
      if (k >= 1 && bundle !== prevBundle && !pePrev) chgErr++;
      prevBundle = bundle;
      pePrev = pix_en;
      if ((line_start && lsPrev) || (frame_start && fsPrev)) widthErr++;
      lsPrev = line_start;
      fsPrev = frame_start;
      if (line_start) begin
        lsCount++;
        if (lsFirst < 0) begin
          lsFirst = k;
          lsFirstVpos = int'(vpos);
        end else if (lsSecond < 0) begin
          lsSecond = k;
        end
      end
      if (!hsync) begin
        run++;
      end else if (run > 0) begin
        if (firstRun < 0) firstRun = run;
        run = 0;
      end
    end
    assertCount++;
    if (chgErr !== 0) begin
      failCount++;
      $display("[TB] FAIL div4_change_timing: got %0d changes not after a strobe, expected 0", chgErr);
    end
    assertCount++;
    if (firstRun !== 384) begin
      failCount++;
      $display("[TB] FAIL div4_hsync_low: got %0d clks, expected 384", firstRun);
    end
    assertCount++;
    if (lsCount !== 2 || lsFirst !== 3197 || lsSecond - lsFirst !== 3200 || lsFirstVpos !== 1) begin
      failCount++;
      $display("[TB] FAIL div4_line_period: count=%0d first=%0d period=%0d vpos=%0d, expected 2 3197 3200 1",
               lsCount, lsFirst, lsSecond - lsFirst, lsFirstVpos);
    end
    assertCount++;
    if (widthErr !== 0) begin
      failCount++;
      $display("[TB] FAIL div4_pulse_width: got %0d wide pulses, expected 0", widthErr);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int fsAt = -1;
    int lsEarly = 0;
    doReset(2);
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      if (hpos === CNT_W'(100) && vpos === CNT_W'(10)) found = 1;
    end
    assertCount++;
    if (!found) begin
      failCount++;
      $display("[TB] FAIL mid_reset_reach: position (100,10) not seen, expected within 20000 clks");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    assertCount++;
    if ({hsync, vsync, active, line_start, frame_start} !== 5'b11000 ||
        hpos !== '0 || vpos !== '0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_values: hs=%b vs=%b act=%b hpos=%0d vpos=%0d ls=%b fs=%b, expected 1 1 0 0 0 0 0",
               hsync, vsync, active, hpos, vpos, line_start, frame_start);
    end
    tick();
    assertCount++;
    if ({hsync, vsync, active, line_start, frame_start} !== 5'b11100 ||
        hpos !== '0 || vpos !== '0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_restart: hs=%b vs=%b act=%b hpos=%0d vpos=%0d ls=%b fs=%b, expected 1 1 1 0 0 0 0",
               hsync, vsync, active, hpos, vpos, line_start, frame_start);
    end
    for (int n = 2; n <= FRAME_CLKS + 10 && fsAt < 0; n++) begin
      tick();
      if (frame_start) fsAt = n;
      if (line_start && n < 801) lsEarly++;
    end
    assertCount++;
    if (fsAt !== FRAME_CLKS + 1 || lsEarly !== 0) begin
      failCount++;
      $display("[TB] FAIL mid_reset_next_frame: fs_at=%0d early_ls=%0d, expected %0d 0",
               fsAt, lsEarly, FRAME_CLKS + 1);
    end
  endtask

  task automatic test_freeze();
    bit found = 0;
    int frozenErr = 0;
    doReset(2);
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (hpos === CNT_W'(199)) found = 1;
    end
    pix_en = 1'b0;
    assertCount++;
    if (!found) begin
      failCount++;
      $display("[TB] FAIL freeze_reach: hpos 199 not seen, expected within 1000 clks");
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hpos !== CNT_W'(200) || vpos !== '0 || hsync !== 1'b1 || active !== 1'b1 ||
          line_start !== 1'b0 || frame_start !== 1'b0) frozenErr++;
    end
    assertCount++;
    if (frozenErr !== 0) begin
      failCount++;
      $display("[TB] FAIL freeze_hold: got %0d clks moved (hpos now %0d), expected 0 at hpos 200",
               frozenErr, hpos);
    end
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    assertCount++;
    if (hpos !== CNT_W'(200)) begin
      failCount++;
      $display("[TB] FAIL freeze_strobe_clk: hpos=%0d, expected 200", hpos);
    end
    tick();
    assertCount++;
    if (hpos !== CNT_W'(201) || active !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL freeze_resume: hpos=%0d act=%b, expected 201 1", hpos, active);
    end
    tick();
    assertCount++;
    if (hpos !== CNT_W'(201)) begin
      failCount++;
      $display("[TB] FAIL freeze_after_resume: hpos=%0d, expected 201", hpos);
    end
  endtask

  // Main sequence
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_div4();
    test_reset_mid();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so a stuck run still ends with a report
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running after 2000000 time units, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
